// File: rtl/scan_uart_pkg.sv
// Purpose : shared FSM encodings, line levels and helpers for the scan return UART.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: SCAN_UART_TX_PARITY_EN (selects 8E1 framing in uart_tx_core).
package scan_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  // Even parity bit: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Purpose : serialises one byte per frame (start, 8 data LSB-first, [parity], stop).
// Latency : byte accepted in IDLE -> start bit on tx the next cycle; frame = 10 (11) * CLKS_PER_BIT.
// Backpressure: in_rdy is high only in IDLE; in_dat is held by the producer until accepted.
// Ports   : clk, reset (async active-high), in_dat/in_vld/in_rdy byte input,
//           tx serial line (registered, idle high), active (frame in progress).
// Macro   : SCAN_UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx_core
  import scan_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_dat,
  input  logic                 in_vld,
  output logic                 in_rdy,
  output logic                 tx,
  output logic                 active
);

  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  tx_state_t              state;
  logic [7:0]             baud_cnt;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   shifter;
`ifdef SCAN_UART_TX_PARITY_EN
  logic                   par_bit;
`endif

  assign in_rdy = (state == IDLE);
  assign active = (state != IDLE);

  // tx is driven from the same register update as the state, so the line
  // level always changes on the cycle the state (or bit) changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= IDLE_LEVEL;
      baud_cnt <= 8'd0;
      bit_idx  <= 3'd0;
      shifter  <= '0;
`ifdef SCAN_UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= IDLE_LEVEL;
          if (in_vld) begin
            shifter  <= in_dat;
`ifdef SCAN_UART_TX_PARITY_EN
            par_bit  <= even_parity(in_dat);
`endif
            tx       <= START_LEVEL;
            baud_cnt <= BIT_LAST;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == 8'd0) begin
            state    <= DATA;
            bit_idx  <= 3'd0;
            tx       <= shifter[0];
            baud_cnt <= BIT_LAST;
          end else begin
            baud_cnt <= baud_cnt - 8'd1;
          end
        end
        DATA: begin
          if (baud_cnt == 8'd0) begin
            baud_cnt <= BIT_LAST;
            if (bit_idx == IDX_LAST) begin
`ifdef SCAN_UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par_bit;
`else
              state <= STOP;
              tx    <= STOP_LEVEL;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shifter[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt - 8'd1;
          end
        end
`ifdef SCAN_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_cnt == 8'd0) begin
            state    <= STOP;
            tx       <= STOP_LEVEL;
            baud_cnt <= BIT_LAST;
          end else begin
            baud_cnt <= baud_cnt - 8'd1;
          end
        end
`endif
        STOP: begin
          if (baud_cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            baud_cnt <= baud_cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: rtl/scan_uart_tx.sv
// Purpose : samples TDO on returned-RTCK rising edges, packs LSB-first bytes, sends them as UART frames.
// Latency : last rtck rise -> start bit on tx in SYNC_STAGES + 3 clk cycles.
// Backpressure: none upstream; one hold byte, a byte completing while hold is full is dropped (sticky overrun).
// Ports   : clk, reset (async active-high), rtck/tdo (async scan return), flush (emit partial byte),
//           tx (serial line, idle high), busy (frame on line or hold valid), overrun (sticky drop flag).
// Macro   : SCAN_UART_TX_PARITY_EN selects 8E1 framing (default 8N1).
module scan_uart_tx
  import scan_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rtck,
  input  logic tdo,
  input  logic flush,
  output logic tx,
  output logic busy,
  output logic overrun
);

  logic [SYNC_STAGES-1:0] rtck_sync;
  logic [SYNC_STAGES-1:0] tdo_sync;
  logic                   prev_rtck;
  logic                   sync_rtck;
  logic                   sync_tdo;
  logic                   rise;

  logic [2:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [DATA_BITS-1:0]   merged;
  logic                   complete;
  logic                   do_flush;
  logic                   done_vld;
  logic [DATA_BITS-1:0]   done_byte;

  logic                   hold_vld;
  logic [DATA_BITS-1:0]   hold_dat;
  logic                   core_rdy;
  logic                   core_active;
  logic                   accept;

  // rtck and tdo share one synchronizer depth so tdo is sampled with the
  // same delay as the rtck edge that qualifies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rtck_sync <= '0;
      tdo_sync  <= '0;
      prev_rtck <= 1'b0;
    end else begin
      rtck_sync <= {rtck_sync[SYNC_STAGES-2:0], rtck};
      tdo_sync  <= {tdo_sync[SYNC_STAGES-2:0], tdo};
      prev_rtck <= rtck_sync[SYNC_STAGES-1];
    end
  end

  assign sync_rtck = rtck_sync[SYNC_STAGES-1];
  assign sync_tdo  = tdo_sync[SYNC_STAGES-1];
  assign rise      = sync_rtck & ~prev_rtck;

  // The rise bit is merged first; a coincident flush then acts on the result.
  always_comb begin
    merged = shift_reg;
    if (rise) merged[bit_cnt] = sync_tdo;
  end

  assign complete = rise & (bit_cnt == 3'd7);
  assign do_flush = flush & ~complete & (rise | (bit_cnt != 3'd0));

  // shift_reg is cleared on every byte hand-off so a flushed partial is zero-padded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= 3'd0;
      shift_reg <= '0;
      done_vld  <= 1'b0;
      done_byte <= '0;
    end else begin
      done_vld <= 1'b0;
      if (complete | do_flush) begin
        done_vld  <= 1'b1;
        done_byte <= merged;
        shift_reg <= '0;
        bit_cnt   <= 3'd0;
      end else if (rise) begin
        shift_reg <= merged;
        bit_cnt   <= bit_cnt + 3'd1;
      end
    end
  end

  assign accept = hold_vld & core_rdy;

  // The hold slot may refill in the same cycle the core takes its byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
      overrun  <= 1'b0;
    end else begin
      if (accept) hold_vld <= 1'b0;
      if (done_vld) begin
        if (!hold_vld || accept) begin
          hold_vld <= 1'b1;
          hold_dat <= done_byte;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .in_dat (hold_dat),
    .in_vld (hold_vld),
    .in_rdy (core_rdy),
    .tx     (tx),
    .active (core_active)
  );

  assign busy = core_active | hold_vld;

endmodule

// File: tb/tb_scan_uart_tx.sv
// Purpose : directed self-checking bench for scan_uart_tx (framing, flush, overrun, reset, coincident events).
// Latency : n/a.
// Backpressure: n/a.
module tb_scan_uart_tx;

  localparam int CPB  = 4;
  localparam int SYNC = 2;
`ifdef SCAN_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * CPB;

  logic clk = 1'b0;
  logic reset;
  logic rtck;
  logic tdo;
  logic flush;
  logic tx;
  logic busy;
  logic overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;

  scan_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rtck    (rtck),
    .tdo     (tdo),
    .flush   (flush),
    .tx      (tx),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: decodes every complete frame seen on tx, sampled on negedges.
  logic [7:0] q_byte[$];
  int         q_start[$];
  bit         q_ok[$];
  bit         q_par[$];
  logic [7:0] m_byte;
  logic       m_first;
  bit         m_ok;
  bit         m_abort;
  bit         m_par;
  int         m_start;

  always begin
    @(negedge clk);
    if (reset === 1'b0 && tx === 1'b0) begin
      m_start = cyc;
      m_ok    = 1'b1;
      m_abort = 1'b0;
      m_par   = 1'b0;
      m_byte  = 8'h00;
      m_first = 1'b0;
      for (int k = 0; k < FRAME_BITS && !m_abort; k++) begin
        for (int c = 0; c < CPB && !m_abort; c++) begin
          if (k != 0 || c != 0) @(negedge clk);
          if (reset !== 1'b0) m_abort = 1'b1;
          else if (c == 0) m_first = tx;
          else if (tx !== m_first) m_ok = 1'b0;
        end
        if (k == 0) begin
          if (m_first !== 1'b0) m_ok = 1'b0;
        end else if (k <= 8) begin
          m_byte = {m_first, m_byte[7:1]};
        end else if (k == FRAME_BITS - 1) begin
          if (m_first !== 1'b1) m_ok = 1'b0;
        end else begin
          m_par = m_first;
        end
      end
      if (!m_abort) begin
        q_byte.push_back(m_byte);
        q_start.push_back(m_start);
        q_ok.push_back(m_ok);
        q_par.push_back(m_par);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_byte.delete();
    q_start.delete();
    q_ok.delete();
    q_par.delete();
  endtask

  // Starts and ends on a negedge.
  task automatic pulse(input logic b, input int hi, input int lo);
    tdo       = b;
    rtck      = 1'b1;
    last_rise = cyc;
    repeat (hi) @(negedge clk);
    rtck = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input int hi, input int lo);
    for (int i = 0; i < 8; i++) pulse(d[i], hi, lo);
  endtask

  // Sends a byte whose last pulse returns right after rtck falls, so the
  // caller can catch the start bit live.
  task automatic send_byte_live(input logic [7:0] d);
    for (int i = 0; i < 7; i++) pulse(d[i], 3, 3);
    pulse(d[7], 3, 0);
  endtask

  task automatic wait_tx_low(input int budget, output int t, output bit seen);
    seen = 1'b0;
    t    = 0;
    for (int i = 0; i < budget; i++) begin
      if (tx === 1'b0) begin
        seen = 1'b1;
        t    = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && q_byte.size() < n; i++) @(negedge clk);
    check(tag, 32'(q_byte.size()), 32'(n));
  endtask

  // Drives a rise whose synchronized edge coincides with a one-cycle flush.
  task automatic rise_with_flush(input logic b);
    tdo       = b;
    rtck      = 1'b1;
    last_rise = cyc;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rtck  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int t0;
  bit seen;

  initial begin
    reset = 1'b1;
    rtck  = 1'b0;
    tdo   = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Byte framing and latency, 0xA5.
    send_byte_live(8'hA5);
    wait_tx_low(40, t0, seen);
    check("a5_start_seen", 32'(seen), 32'd1);
    check("a5_latency", 32'(t0 - last_rise), 32'(SYNC + 3));
    repeat (FRAME_CLKS - 1) @(negedge clk);
    check("a5_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    check("a5_busy_fall", 32'(busy), 32'd0);
    wait_frames("a5_frames", 1, 20);
    check("a5_byte", 32'(q_byte[0]), 32'h0A5);
    check("a5_framing", 32'(q_ok[0]), 32'd1);
`ifdef SCAN_UART_TX_PARITY_EN
    check("a5_parity", 32'(q_par[0]), 32'd0);
`endif
    clear_q();

    // Flush of a 3-bit partial, then a no-op flush.
    pulse(1'b1, 3, 3);
    pulse(1'b1, 3, 3);
    pulse(1'b0, 3, 3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_frames("flush_frames", 1, 100);
    check("flush_byte", 32'(q_byte[0]), 32'h03);
    check("flush_framing", 32'(q_ok[0]), 32'd1);
    clear_q();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (80) @(negedge clk);
    check("flush_empty_frames", 32'(q_byte.size()), 32'd0);
    check("flush_empty_busy", 32'(busy), 32'd0);

    // Overrun: 24 bits faster than one frame time.
    send_byte(8'h11, 1, 1);
    send_byte(8'h22, 1, 1);
    send_byte(8'h33, 1, 1);
    wait_frames("ovr_frames", 2, 200);
    check("ovr_byte0", 32'(q_byte[0]), 32'h11);
    check("ovr_byte1", 32'(q_byte[1]), 32'h22);
    check("ovr_framing", 32'(q_ok[0] & q_ok[1]), 32'd1);
    // Back-to-back: the single IDLE cycle after STOP is the only spacing.
    check("ovr_gap", 32'(q_start[1] - q_start[0]), 32'(FRAME_CLKS + 1));
    check("ovr_flag", 32'(overrun), 32'd1);
    repeat (100) @(negedge clk);
    check("ovr_no_third", 32'(q_byte.size()), 32'd2);
    check("ovr_sticky", 32'(overrun), 32'd1);
    clear_q();

    // Reset during DATA bit 3 of 0xA5 (that bit is 0 on the line).
    send_byte_live(8'hA5);
    wait_tx_low(40, t0, seen);
    check("rst_start_seen", 32'(seen), 32'd1);
    repeat (17) @(negedge clk);
    check("rst_tx_before", 32'(tx), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("rst_tx_async", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_frame_abandoned", 32'(q_byte.size()), 32'd0);
    send_byte(8'h3C, 3, 3);
    wait_frames("rst_new_frames", 1, 200);
    check("rst_new_byte", 32'(q_byte[0]), 32'h3C);
    check("rst_new_framing", 32'(q_ok[0]), 32'd1);
    repeat (20) @(negedge clk);
    clear_q();

    // Flush coincident with the 8th rise: one 0xFF frame only.
    for (int i = 0; i < 7; i++) pulse(1'b1, 3, 3);
    rise_with_flush(1'b1);
    wait_frames("sim8_frames", 1, 200);
    repeat (80) @(negedge clk);
    check("sim8_one_frame", 32'(q_byte.size()), 32'd1);
    check("sim8_byte", 32'(q_byte[0]), 32'hFF);
    clear_q();

    // Flush coincident with the 2nd rise: 0x03 frame.
    pulse(1'b1, 3, 3);
    rise_with_flush(1'b1);
    wait_frames("sim2_frames", 1, 200);
    repeat (80) @(negedge clk);
    check("sim2_one_frame", 32'(q_byte.size()), 32'd1);
    check("sim2_byte", 32'(q_byte[0]), 32'h03);
    clear_q();

`ifdef SCAN_UART_TX_PARITY_EN
    // Odd number of ones -> parity bit 1; frame length via busy.
    send_byte_live(8'h07);
    wait_tx_low(40, t0, seen);
    check("p07_start_seen", 32'(seen), 32'd1);
    repeat (43) @(negedge clk);
    check("p07_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    check("p07_busy_fall", 32'(busy), 32'd0);
    wait_frames("p07_frames", 1, 20);
    check("p07_byte", 32'(q_byte[0]), 32'h07);
    check("p07_parity", 32'(q_par[0]), 32'd1);
    check("p07_framing", 32'(q_ok[0]), 32'd1);
    clear_q();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_uart_tx.md
Name: scan_uart_tx

Overview:
- Return path from the scan chain to the host.
- Samples TDO on rising edges of the returned scan clock (RTCK) from the far end of the tap chain.
- Packs the sampled bits LSB-first into bytes and sends each byte as an asynchronous serial 8N1 frame.
- Complements the serial-in controller side; runs in the uart_clk domain beside the controller.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal range 2..255.
- SYNC_STAGES, 2, synchronizer depth for rtck and tdo; minimum 2.

Ports:
- clk  input  1  uart_clk domain clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- rtck  input  1  returned scan clock, asynchronous to clk.
- tdo  input  1  scan data out of last tap; valid around rising rtck.
- flush  input  1  single-cycle pulse; emit pending partial byte, zero-padded.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is on the line or the hold byte is valid.
- overrun  output  1  sticky; a completed byte was dropped.

Behaviour:
- Reset values: tx=1, busy=0, overrun=0, bit count=0, shift reg=0, hold empty, FSM=IDLE, baud counter=0.
- Sync:
  - rtck and tdo each pass through SYNC_STAGES flops; equal depth keeps them aligned.
  - Edge detect: one extra rtck flop. rise = sync_rtck & ~prev_rtck.
- Assembly:
  - On rise: shift_reg[count] <= sync_tdo; count <= count+1 (3-bit count plus a done condition).
  - On the 8th bit: the byte is complete and count wraps to 0.
- Flush:
  - flush with count>0 completes the byte with bits [7:count]=0; count <= 0.
  - flush with count=0 is a no-op.
- Flush and rise in the same cycle:
  - The rise bit is applied first, then the flush acts on the resulting partial.
  - If the rise completes the byte, it is a normal completion and the flush is a no-op.
- Hold buffer (1 entry):
  - A completed byte loads into hold if hold is empty.
  - If hold is full, the byte is dropped and overrun <= 1.
  - overrun is cleared only by reset.
- TX FSM:
  - States: IDLE, START, DATA, STOP.
  - IDLE: when hold is valid, load the TX shifter, clear hold, go to START next cycle. The hold can then accept a new byte in the same cycle it empties.
  - START: tx=0.
  - DATA: 8 bits LSB-first, tracked by a 3-bit index.
  - STOP: tx=1.
  - Each bit lasts exactly CLKS_PER_BIT cycles, timed by the baud counter. The counter reloads at each state or bit change.
  - STOP → IDLE after its full bit time. Back-to-back frames have no extra idle gap, so the next START begins on the cycle after IDLE.
- Latency:
  - Last rtck edge to the start bit on tx: SYNC_STAGES + 3 clk cycles.
  - One frame lasts 10*CLKS_PER_BIT cycles.
- busy = (state != IDLE) | hold_valid.
- Reset mid-frame: tx goes to 1 immediately (asynchronously). The partial frame is abandoned and not resumed.

Optional Feature:
- Macro: SCAN_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and transmits even parity, i.e. the XOR of the 8 data bits.
  - Frame is 11 bits (8E1); frame time is 11*CLKS_PER_BIT.
- Undefined:
  - No PARITY state and no parity logic; 8N1 framing with a 10-bit frame.

Decomposition:
- Shared package/include scan_uart_pkg, holding:
  - FSM state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit.
  - Constants: DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1.
- One sub-module, uart_tx_core:
  - Holds the baud counter, FSM and frame shifter.
  - Interface: byte in with valid/ready; tx and active out.
- The top module keeps the synchronizers, edge detect, bit assembly, hold buffer and overrun.

Test Plan:
- Byte framing: CLKS_PER_BIT=4; 8 rtck pulses, each 6 clk wide, carrying tdo=1,0,1,0,0,1,0,1 (0xA5) → tx = 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 clk; busy falls 40 clk after the start bit.
- Flush: 3 rtck pulses with tdo=1,1,0, then a flush pulse → byte 0x03 transmitted; a second flush with count=0 produces no frame.
- Overrun: 24 bits clocked faster than one frame time (bytes 0x11, 0x22, 0x33) → 0x11 and 0x22 transmitted back-to-back with no gap; 0x33 dropped; overrun=1 until reset.
- Reset mid-frame: reset asserted during DATA bit 3 → tx=1 in the same cycle, busy=0, overrun=0; a new byte after reset is framed correctly.
- Simultaneous events: flush coincident with the 8th rise (tdo bits all 1 = 0xFF) → exactly one 0xFF frame; flush coincident with the 2nd rise (bits 1,1) → 0x03 frame.
- Parity (SCAN_UART_TX_PARITY_EN defined): send 0xA5 → parity bit 0; send 0x07 → parity bit 1; frame length 44 clk.
